instruction_scheduler: RTL and testbench
========================================

# instruction_scheduler

Merges instruction streams from two requesters (host command port A, sprite/asset loader port B) into the single 32-bit instruction port of the pixel generator. It provides round-robin arbitration, an in-order FIFO, and issue gating. SET_SPRITE instructions are spaced so the generator's sprite read-modify-write sequence is never overrun. Pixel and sprite writes can optionally be held until blanking. Sits between the command sources and the pixel generator's `i_instruction` / `i_instruction_ready`.

## Interface
- `FIFO_AW`, default 3: FIFO address width; depth = 2**FIFO_AW entries.
- `SPRITE_GAP`, default 4: minimum cycles between consecutive SET_SPRITE issues.
- `BLANK_GATE`, default 1: when 1, SET_PIXEL (0x07) and SET_SPRITE (0x08) issue only while `i_blank` = 1.
- `i_clk`  in  1  sole clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_a_instruction`  in  32  port A instruction; opcode [7:0], args [31:8].
- `i_a_valid`  in  1  port A request.
- `o_a_ready`  out  1  port A accept; transfer when valid && ready.
- `i_b_instruction`  in  32  port B instruction.
- `i_b_valid`  in  1  port B request.
- `o_b_ready`  out  1  port B accept.
- `i_blank`  in  1  high during video blanking.
- `o_instruction`  out  32  instruction to the pixel generator; 0 when not issuing.
- `o_instruction_ready`  out  1  one-cycle issue strobe.
- `o_discard`  out  1  one-cycle pulse: invalid opcode dropped.
- `o_fifo_count`  out  FIFO_AW+1  current occupancy.

## Operation
- **Arbitration**
  - Registered round-robin pointer `last`; reset value = B, so A wins the first tie.
  - `o_a_ready = !full && (!i_b_valid || last==B)`.
  - `o_b_ready = !full && (!i_a_valid || last==A)`.
  - Ready outputs are combinational from the valids and full. At most one transfer per cycle.
  - `last` updates only on a transfer.
  - Full is evaluated before any same-cycle pop. There is no push-through at full.
- **FIFO**
  - In order, 2**FIFO_AW × 32 bits.
  - Read/write pointers are FIFO_AW bits and wrap modulo depth. Count is FIFO_AW+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
- **Issue (head of FIFO, evaluated every cycle)**
  - Opcode 0x00 or > 0x08: pop the entry, do not issue, pulse `o_discard` next cycle. This takes one cycle per entry.
  - Opcode 0x01–0x06: issue immediately.
  - Opcode 0x07: issue if `BLANK_GATE`==0 or `i_blank`.
  - Opcode 0x08: issue if (`BLANK_GATE`==0 or `i_blank`) and `gap_cnt`==0.
  - A blocked head blocks all later entries. Ordering is never violated.
  - Issue = pop. The next cycle registers `o_instruction` = entry and `o_instruction_ready` = 1. Otherwise both are 0.
- **Gap counter**
  - Width $clog2(SPRITE_GAP+1).
  - Loaded with SPRITE_GAP-1 in the cycle the SET_SPRITE strobe is output.
  - Decrements to 0 and saturates.
  - Non-sprite opcodes may issue while `gap_cnt` ≠ 0.
- **Reset**
  - Empties the FIFO and zeroes the pointers and `gap_cnt`.
  - Sets `last` = B.
  - Drives `o_instruction` = 0, `o_instruction_ready` = 0, `o_discard` = 0, `o_fifo_count` = 0 on the following cycle.
  - Reset mid-stream drops all queued entries; no partial issue occurs.

## Timing
- A push accepted in cycle t is head-visible in t+1. With the gate open, it issues (strobe high) in t+2. Minimum latency is 2 cycles.
- Sustained throughput: one issue per cycle for non-sprite opcodes.
- SET_SPRITE strobes are at least SPRITE_GAP cycles apart. With the default of 4, strobes at t and t+4 are legal, but t+3 is not.
- `i_blank` is sampled in the pop cycle. Deassertion after the pop does not cancel the issue.
- `o_fifo_count` reflects pushes and pops from the previous edge.

## Test plan
- **Tie arbitration:** after reset, A and B both valid with 0x02 and 0x03 for 4 cycles → accepted A, B, A, B; issued 0x02, 0x03, 0x02, 0x03 starting 2 cycles after the first accept.
- **Sprite spacing:** queue three SET_SPRITE (0x00000108, 0x00000208, 0x00000308), `i_blank`=1 → strobes at t, t+4, t+8. Insert 0x05 between the first two → 0x05 issues at t+1 and sprites stay at t, t+4.
- **Blank gating:** `i_blank`=0, queue 0x00012307 then 0x04 → nothing issues and count=2. Raise `i_blank` → 0x00012307 issues, 0x04 issues the next cycle.
- **Full FIFO:** depth 8, push 9 back-to-back from A with `i_blank`=0 and SET_PIXEL head → ready drops after 8 accepts, count=8, the 9th is held by A until a pop.
- **Discard:** queue 0x000000FF, then 0x06 → `o_discard` pulses once, 0x06 issues, `o_instruction` never shows 0xFF.
- **Mid-stream reset:** reset asserted with 5 entries queued and the gap active → count=0, no strobe, and the next SET_SPRITE issues without any gap wait.

Source files
------------

// File: rtl/instruction_scheduler.sv
// Instruction scheduler: two requesters merged into one in-order queue feeding the pixel generator.
// sync_fifo is the small generic queue used for the in-order buffer.

// Generic synchronous FIFO: in-order storage with occupancy count.
// Latency: a push is visible at the head one cycle later; the head reads combinationally.
// Backpressure: push is ignored when full and pop is ignored when empty, so callers gate on full/empty.
module sync_fifo #(
  parameter int AW = 3,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Round-robin merge of ports A/B into an in-order queue, issuing the head to the pixel generator.
// Latency: accept in cycle t, head in t+1, issue strobe in t+2 when the head is not gated.
// Backpressure: ready drops while the queue is full (no push-through); a gated head stalls everything behind it.
module instruction_scheduler #(
  parameter int FIFO_AW    = 3,
  parameter int SPRITE_GAP = 4,
  parameter bit BLANK_GATE = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [31:0]        i_a_instruction,
  input  logic               i_a_valid,
  output logic               o_a_ready,
  input  logic [31:0]        i_b_instruction,
  input  logic               i_b_valid,
  output logic               o_b_ready,
  input  logic               i_blank,
  output logic [31:0]        o_instruction,
  output logic               o_instruction_ready,
  output logic               o_discard,
  output logic [FIFO_AW:0]   o_fifo_count
);
  localparam int GAP_W    = (SPRITE_GAP > 0) ? $clog2(SPRITE_GAP + 1) : 1;
  localparam int GAP_LOAD = (SPRITE_GAP > 1) ? (SPRITE_GAP - 1) : 0;

  localparam logic [7:0] OP_SET_PIXEL  = 8'h07;
  localparam logic [7:0] OP_SET_SPRITE = 8'h08;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  src_t             last;
  logic             full;
  logic             empty;
  logic [31:0]      head;
  logic [7:0]       opcode;
  logic             a_xfer;
  logic             b_xfer;
  logic             push;
  logic [31:0]      push_dat;
  logic             pop;
  logic             issue;
  logic             drop;
  logic             gate_open;
  logic [GAP_W-1:0] gap_cnt;

  // Ready is computed from the occupancy before any same-cycle pop.
  assign o_a_ready = !full && (!i_b_valid || (last == SRC_B));
  assign o_b_ready = !full && (!i_a_valid || (last == SRC_A));
  assign a_xfer    = i_a_valid && o_a_ready;
  assign b_xfer    = i_b_valid && o_b_ready;
  assign push      = a_xfer || b_xfer;
  assign push_dat  = a_xfer ? i_a_instruction : i_b_instruction;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      last <= SRC_B;
    end else if (a_xfer) begin
      last <= SRC_A;
    end else if (b_xfer) begin
      last <= SRC_B;
    end
  end

  sync_fifo #(
    .AW (FIFO_AW),
    .W  (32)
  ) u_fifo (
    .clk      (i_clk),
    .reset    (i_reset),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .count    (o_fifo_count),
    .full     (full),
    .empty    (empty)
  );

  assign opcode    = head[7:0];
  assign gate_open = !BLANK_GATE || i_blank;

  always_comb begin
    issue = 1'b0;
    drop  = 1'b0;
    if (!empty) begin
      if ((opcode == 8'h00) || (opcode > OP_SET_SPRITE)) begin
        drop = 1'b1;
      end else if (opcode == OP_SET_PIXEL) begin
        issue = gate_open;
      end else if (opcode == OP_SET_SPRITE) begin
        issue = gate_open && (gap_cnt == '0);
      end else begin
        issue = 1'b1;
      end
    end
  end

  assign pop = issue || drop;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_instruction       <= '0;
      o_instruction_ready <= 1'b0;
      o_discard           <= 1'b0;
    end else begin
      o_instruction       <= issue ? head : '0;
      o_instruction_ready <= issue;
      o_discard           <= drop;
    end
  end

  // Loaded on the edge that raises the sprite strobe, so the next sprite strobe lands SPRITE_GAP cycles later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      gap_cnt <= '0;
    end else if (issue && (opcode == OP_SET_SPRITE)) begin
      gap_cnt <= GAP_W'(GAP_LOAD);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end
endmodule

// File: tb/tb_instruction_scheduler.sv
// Directed bench for instruction_scheduler: arbitration, sprite spacing, blank gating, full, discard, reset.
module tb_instruction_scheduler;
  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_a_instruction;
  logic        i_a_valid;
  logic        o_a_ready;
  logic [31:0] i_b_instruction;
  logic        i_b_valid;
  logic        o_b_ready;
  logic        i_blank;
  logic [31:0] o_instruction;
  logic        o_instruction_ready;
  logic        o_discard;
  logic [3:0]  o_fifo_count;

  instruction_scheduler #(
    .FIFO_AW    (3),
    .SPRITE_GAP (4),
    .BLANK_GATE (1'b1)
  ) dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_a_instruction     (i_a_instruction),
    .i_a_valid           (i_a_valid),
    .o_a_ready           (o_a_ready),
    .i_b_instruction     (i_b_instruction),
    .i_b_valid           (i_b_valid),
    .o_b_ready           (o_b_ready),
    .i_blank             (i_blank),
    .o_instruction       (o_instruction),
    .o_instruction_ready (o_instruction_ready),
    .o_discard           (o_discard),
    .o_fifo_count        (o_fifo_count)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Issue/discard log stamped with the cycle number, sampled mid-cycle.
  int          log_cyc[$];
  logic [31:0] log_dat[$];
  int          disc_cyc[$];
  int          bad_idle = 0;
  int          ff_seen  = 0;

  always @(negedge i_clk) begin
    if (o_instruction_ready) begin
      log_cyc.push_back(cyc);
      log_dat.push_back(o_instruction);
      if (o_instruction[7:0] == 8'hFF) ff_seen++;
    end else if (o_instruction != 32'h0) begin
      bad_idle++;
    end
    if (o_discard) disc_cyc.push_back(cyc);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_dat(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] d);
    i_a_valid       = 1'b1;
    i_a_instruction = d;
    step();
    i_a_valid       = 1'b0;
  endtask

  task automatic clear_logs();
    log_cyc.delete();
    log_dat.delete();
    disc_cyc.delete();
  endtask

  task automatic exp_issue(input string tag, input int k, input int ecyc, input logic [31:0] edat);
    check_dat({tag, "_present"}, 64'(log_cyc.size() > k), 64'(1));
    if (log_cyc.size() > k) begin
      check_dat({tag, "_cyc"}, 64'(log_cyc[k]), 64'(ecyc));
      check_dat({tag, "_dat"}, 64'(log_dat[k]), 64'(edat));
    end
  endtask

  int c0;
  int c1;
  int p;
  int idx;

  initial begin
    i_reset         = 1'b1;
    i_a_instruction = 32'h0;
    i_a_valid       = 1'b0;
    i_b_instruction = 32'h0;
    i_b_valid       = 1'b0;
    i_blank         = 1'b0;
    step();
    step();
    i_reset = 1'b0;

    check_dat("rst_instr", 64'(o_instruction), 64'(0));
    check_dat("rst_strobe", 64'(o_instruction_ready), 64'(0));
    check_dat("rst_discard", 64'(o_discard), 64'(0));
    check_dat("rst_count", 64'(o_fifo_count), 64'(0));
    check_dat("rst_a_rdy", 64'(o_a_ready), 64'(1));

    // Tie arbitration: A wins first, then alternate.
    clear_logs();
    c0 = cyc;
    i_a_valid       = 1'b1;
    i_a_instruction = 32'h0000_0002;
    i_b_valid       = 1'b1;
    i_b_instruction = 32'h0000_0003;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_dat("tie_a_rdy", 64'(o_a_ready), 64'((i % 2) == 0));
      check_dat("tie_b_rdy", 64'(o_b_ready), 64'((i % 2) == 1));
      step();
    end
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    repeat (6) step();
    check_dat("tie_n", 64'(log_cyc.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      exp_issue("tie", k, c0 + 2 + k, ((k % 2) == 0) ? 32'h2 : 32'h3);

    // Sprite spacing: three sprites, strobes 4 cycles apart.
    i_blank = 1'b1;
    clear_logs();
    c0 = cyc;
    push_a(32'h0000_0108);
    push_a(32'h0000_0208);
    push_a(32'h0000_0308);
    repeat (12) step();
    check_dat("spr_n", 64'(log_cyc.size()), 64'(3));
    exp_issue("spr0", 0, c0 + 2,  32'h0000_0108);
    exp_issue("spr1", 1, c0 + 6,  32'h0000_0208);
    exp_issue("spr2", 2, c0 + 10, 32'h0000_0308);

    // A non-sprite slips in while the gap is running.
    clear_logs();
    c0 = cyc;
    push_a(32'h0000_0108);
    push_a(32'h0000_0005);
    push_a(32'h0000_0208);
    repeat (10) step();
    check_dat("sprmix_n", 64'(log_cyc.size()), 64'(3));
    exp_issue("sprmix0", 0, c0 + 2, 32'h0000_0108);
    exp_issue("sprmix1", 1, c0 + 3, 32'h0000_0005);
    exp_issue("sprmix2", 2, c0 + 6, 32'h0000_0208);

    // Blank gating: pixel head holds everything until blank rises.
    i_blank = 1'b0;
    clear_logs();
    push_a(32'h0001_2307);
    push_a(32'h0000_0004);
    repeat (3) step();
    check_dat("blk_count", 64'(o_fifo_count), 64'(2));
    check_dat("blk_held", 64'(log_cyc.size()), 64'(0));
    c1 = cyc;
    i_blank = 1'b1;
    step();
    i_blank = 1'b0;
    repeat (4) step();
    check_dat("blk_n", 64'(log_cyc.size()), 64'(2));
    exp_issue("blk0", 0, c1 + 1, 32'h0001_2307);
    exp_issue("blk1", 1, c1 + 2, 32'h0000_0004);

    // Full FIFO: 8 accepts, 9th held until a pop frees a slot.
    clear_logs();
    idx = 0;
    for (int i = 0; i < 9; i++) begin
      i_a_valid       = 1'b1;
      i_a_instruction = {24'(idx + 1), 8'h07};
      #1;
      check_dat("full_rdy", 64'(o_a_ready), 64'(i < 8));
      check_dat("full_cnt", 64'(o_fifo_count), 64'(i));
      if (o_a_ready) idx++;
      step();
    end
    repeat (2) begin
      #1;
      check_dat("full_hold_rdy", 64'(o_a_ready), 64'(0));
      check_dat("full_hold_cnt", 64'(o_fifo_count), 64'(8));
      step();
    end
    p = cyc;
    i_blank = 1'b1;
    #1;
    check_dat("full_no_pushthru", 64'(o_a_ready), 64'(0));
    step();
    check_dat("full_after_pop_cnt", 64'(o_fifo_count), 64'(7));
    check_dat("full_after_pop_rdy", 64'(o_a_ready), 64'(1));
    step();
    i_a_valid = 1'b0;
    repeat (12) step();
    i_blank = 1'b0;
    check_dat("full_n", 64'(log_cyc.size()), 64'(9));
    for (int k = 0; k < 9; k++)
      exp_issue("full", k, p + 1 + k, {24'(k + 1), 8'h07});
    check_dat("full_drained", 64'(o_fifo_count), 64'(0));

    // Discard: invalid opcode dropped with one pulse, next entry issues.
    i_blank = 1'b1;
    clear_logs();
    c0 = cyc;
    push_a(32'h0000_00FF);
    push_a(32'h0000_0006);
    repeat (5) step();
    check_dat("disc_n", 64'(disc_cyc.size()), 64'(1));
    if (disc_cyc.size() > 0) check_dat("disc_cyc", 64'(disc_cyc[0]), 64'(c0 + 2));
    check_dat("disc_issue_n", 64'(log_cyc.size()), 64'(1));
    exp_issue("disc", 0, c0 + 3, 32'h0000_0006);
    check_dat("disc_no_ff", 64'(ff_seen), 64'(0));

    // Mid-stream reset with five queued entries and the sprite gap running.
    i_blank = 1'b0;
    clear_logs();
    c0 = cyc;
    push_a(32'h0000_0108);
    push_a(32'h0000_0208);
    push_a(32'h0000_0001);
    push_a(32'h0000_0002);
    push_a(32'h0000_0003);
    push_a(32'h0000_0004);
    check_dat("mrst_pre_cnt", 64'(o_fifo_count), 64'(6));
    i_blank = 1'b1;
    step();
    i_blank = 1'b0;
    check_dat("mrst_queued", 64'(o_fifo_count), 64'(5));
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check_dat("mrst_cnt", 64'(o_fifo_count), 64'(0));
    check_dat("mrst_strobe", 64'(o_instruction_ready), 64'(0));
    check_dat("mrst_instr", 64'(o_instruction), 64'(0));
    i_blank = 1'b1;
    push_a(32'h0000_0308);
    repeat (6) step();
    check_dat("mrst_n", 64'(log_cyc.size()), 64'(2));
    exp_issue("mrst0", 0, c0 + 7,  32'h0000_0108);
    exp_issue("mrst1", 1, c0 + 10, 32'h0000_0308);
    check_dat("mrst_empty", 64'(o_fifo_count), 64'(0));

    check_dat("idle_instr_zero", 64'(bad_idle), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
